// File: rtl/weight_bank_loader.sv
// Run-time loadable weight bank: NC columns of DEPTH signed words, streamed in column-major
// over a valid/ready port, read back through two registered ports with valid and error flags.
module weight_bank_loader #(
    parameter int NC    = 10,
    parameter int WIDTH = 8,
    parameter int DEPTH = 784,
    parameter int AW    = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_start,
    input  logic                   ld_valid,
    output logic                   ld_ready,
    input  logic [WIDTH-1:0]       ld_data,
    output logic                   load_done,
    output logic                   bank_ready,
    input  logic                   rd_en,
    input  logic                   rd_valid2,
    input  logic [AW-1:0]          addr1,
    input  logic [AW-1:0]          addr2,
    output logic [NC*WIDTH-1:0]    dout1,
    output logic [NC*WIDTH-1:0]    dout2,
    output logic                   dout_valid,
    output logic                   rd_err
);

    localparam int CW = (NC > 1) ? $clog2(NC) : 1;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] LAST_COL  = CW'(NC - 1);
    localparam logic [IW-1:0] LAST_WORD = IW'(DEPTH - 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_READY
    } state_t;

    state_t state, state_nx;

    logic [CW-1:0]    col;
    logic [IW-1:0]    waddr;
    logic             accept;
    logic             last_word;
    logic             load_entry;
    logic             rd_req;
    logic             oob1;
    logic             oob2;
    logic [IW-1:0]    ra1;
    logic [IW-1:0]    ra2;
    logic [NC*WIDTH-1:0] rd1_nx;
    logic [NC*WIDTH-1:0] rd2_nx;

    logic [WIDTH-1:0] mem [NC][DEPTH];

    assign ld_ready   = (state == S_LOAD);
    assign bank_ready = (state == S_READY);
    assign accept     = ld_valid && ld_ready;
    assign last_word  = accept && (col == LAST_COL) && (waddr == LAST_WORD);
    assign load_entry = (state != S_LOAD) && (state_nx == S_LOAD);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: every signal driven here gets its default first so no path infers a latch.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (load_start) state_nx = S_LOAD;
            S_LOAD:  if (last_word)  state_nx = S_READY;
            S_READY: if (load_start) state_nx = S_LOAD;
            default: state_nx = S_IDLE;
        endcase
    end

    // Column-major write pointer: waddr runs through a column, then col advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col       <= '0;
            waddr     <= '0;
            load_done <= 1'b0;
        end else begin
            load_done <= last_word;
            if (load_entry) begin
                col   <= '0;
                waddr <= '0;
            end else if (accept) begin
                if (waddr == LAST_WORD) begin
                    waddr <= '0;
                    col   <= col + 1'b1;
                end else begin
                    waddr <= waddr + 1'b1;
                end
            end
        end
    end

    // NOTE: the weight array has no reset; contents persist across rst and are only
    // trusted once bank_ready rises after a complete load.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[col][waddr] <= ld_data;
        end
    end

    assign rd_req = rd_en && bank_ready;
    assign oob1   = (addr1 > LAST_ADDR);
    assign oob2   = (addr2 > LAST_ADDR);
    assign ra1    = addr1[IW-1:0];
    assign ra2    = addr2[IW-1:0];

    // Out-of-range lanes read as zero; a masked port 2 reads as zero regardless of address.
    for (genvar c = 0; c < NC; c++) begin : g_lane
        assign rd1_nx[c*WIDTH +: WIDTH] = oob1 ? '0 : mem[c][ra1];
        assign rd2_nx[c*WIDTH +: WIDTH] = (!rd_valid2 || oob2) ? '0 : mem[c][ra2];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout1      <= '0;
            dout2      <= '0;
            dout_valid <= 1'b0;
            rd_err     <= 1'b0;
        end else begin
            dout_valid <= rd_req;
            rd_err     <= rd_req && (oob1 || (rd_valid2 && oob2));
            if (rd_req) begin
                dout1 <= rd1_nx;
                dout2 <= rd2_nx;
            end
        end
    end

endmodule
